// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: operation codes, datapath widths,
// controller state encoding and the per-operation latency lookup.
package alu_pkg;

  localparam int OPERAND_W = 512;
  localparam int RESULT_W  = 1024;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Cycles from acceptance to result; undefined opcodes complete in one cycle.
  function automatic logic [3:0] op_latency(input logic [1:0] op,
                                            input int add_lat,
                                            input int mul_lat);
    case (op)
      OP_ADD:  return 4'(add_lat);
      OP_MUL:  return 4'(mul_lat);
      default: return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational wide ALU: 513-bit sum zero-extended to RESULT_W, or the full
// 1024-bit product. Undefined opcodes yield zero.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [OPERAND_W-1:0] i_operand1,
  input  logic [OPERAND_W-1:0] i_operand2,
  input  logic [1:0]           i_operation,
  output logic [RESULT_W-1:0]  o_result
);

  logic [OPERAND_W:0] w_sum;

  // Carry-preserving sum; the carry lands in bit OPERAND_W of the result.
  always_comb begin
    w_sum = {1'b0, i_operand1} + {1'b0, i_operand2};
  end

  // Select the result for the requested operation.
  always_comb begin
    o_result = '0;
    case (i_operation)
      OP_ADD:  o_result = {{(RESULT_W-OPERAND_W-1){1'b0}}, w_sum};
      OP_MUL:  o_result = RESULT_W'(i_operand1) * RESULT_W'(i_operand2);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared wide ALU; one command in
// flight at a time. Optional per-requester grant counters are built when the
// macro ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ADD_LAT = 1,
  parameter int MUL_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OPERAND_W-1:0] req0_operand1,
  input  logic [OPERAND_W-1:0] req0_operand2,
  input  logic [1:0]           req0_operation,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OPERAND_W-1:0] req1_operand1,
  input  logic [OPERAND_W-1:0] req1_operand2,
  input  logic [1:0]           req1_operation,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RESULT_W-1:0]  out_result,
  output logic                 out_id,
  output state_t               o_dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]          grant_cnt0,
  output logic [31:0]          grant_cnt1
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. reqN_ready is high only in IDLE, only for the arbitration winner
  // and never during reset; out_valid may not depend on out_ready and, once
  // high, result and id hold until the transfer.

  state_t                 r_state, w_next_state;
  logic [OPERAND_W-1:0]   r_op1, r_op2;
  logic [1:0]             r_op;
  logic                   r_id;
  logic [3:0]             r_count;
  logic                   r_last_grant;
  logic [RESULT_W-1:0]    r_result;
  logic                   r_out_id;
  logic [RESULT_W-1:0]    w_alu_result;
  logic                   w_any_valid, w_grant_id, w_accept;
  logic [OPERAND_W-1:0]   w_sel_op1, w_sel_op2;
  logic [1:0]             w_sel_op;

  // Round-robin pick: a lone requester wins; a tie goes to the one not granted last.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_accept    = (r_state == ST_IDLE) && w_any_valid && !rst;
    req0_ready  = w_accept && !w_grant_id;
    req1_ready  = w_accept && w_grant_id;
    w_sel_op1   = w_grant_id ? req1_operand1  : req0_operand1;
    w_sel_op2   = w_grant_id ? req1_operand2  : req0_operand2;
    w_sel_op    = w_grant_id ? req1_operation : req0_operation;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: accept -> count down latency -> hold result until taken.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)        w_next_state = ST_BUSY;
      ST_BUSY: if (r_count == 4'd0) w_next_state = ST_DONE;
      ST_DONE: if (out_ready)       w_next_state = ST_IDLE;
      default:                      w_next_state = ST_IDLE;
    endcase
  end

  // Command capture, latency countdown and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1        <= '0;
      r_op2        <= '0;
      r_op         <= '0;
      r_id         <= 1'b0;
      r_count      <= '0;
      r_last_grant <= 1'b1;
      r_result     <= '0;
      r_out_id     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op1        <= w_sel_op1;
        r_op2        <= w_sel_op2;
        r_op         <= w_sel_op;
        r_id         <= w_grant_id;
        r_count      <= op_latency(w_sel_op, ADD_LAT, MUL_LAT) - 4'd1;
        r_last_grant <= w_grant_id;
      end
      if (r_state == ST_BUSY) begin
        if (r_count == 4'd0) begin
          r_result <= w_alu_result;
          r_out_id <= r_id;
        end else begin
          r_count <= r_count - 4'd1;
        end
      end
    end
  end

  alu_arbiter_alu u_alu (
    .i_operand1  (r_op1),
    .i_operand2  (r_op2),
    .i_operation (r_op),
    .o_result    (w_alu_result)
  );

  assign out_valid   = (r_state == ST_DONE);
  assign out_result  = r_result;
  assign out_id      = r_out_id;
  assign o_dbg_state = r_state;

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_grant_cnt0, r_grant_cnt1;

  // Count accepted commands per requester; counters wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
      if (req1_valid && req1_ready) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int ADD_LAT = 1;
  localparam int MUL_LAT = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [511:0] req0_operand1, req0_operand2, req1_operand1, req1_operand2;
  logic [1:0]   req0_operation, req1_operation;
  logic         out_valid, out_ready, out_id;
  logic [1023:0] out_result;
  state_t       dbg_state;
`ifdef ALU_ARB_STATS_EN
  logic [31:0]  grant_cnt0, grant_cnt1;
`endif

  alu_arbiter #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_operand1(req0_operand1), .req0_operand2(req0_operand2), .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_operand1(req1_operand1), .req1_operand2(req1_operand2), .req1_operation(req1_operation),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_id(out_id),
    .o_dbg_state(dbg_state)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // check bookkeeping
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (low 256 bits shown, upper bits differ=%0d)",
                  name, act[255:0], exp[255:0], act[1023:256] !== exp[1023:256]);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out, got no DUT event, expected one", name);
  endtask

  // reference ALU and latency, straight from the arithmetic definition
  function automatic logic [1023:0] ref_alu(input logic [1:0] op, input logic [511:0] a, input logic [511:0] b);
    logic [1023:0] wa, wb;
    wa = 1024'(a);
    wb = 1024'(b);
    if (op == 2'b00) return wa + wb;
    if (op == 2'b01) return wa * wb;
    return '0;
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    if (op == 2'b00) return ADD_LAT;
    if (op == 2'b01) return MUL_LAT;
    return 1;
  endfunction

  // transaction-level model state and logs
  int            cyc = 0;
  bit            m_busy = 0;
  int            m_valid_cyc = 0;
  logic [1023:0] m_res = '0;
  logic [1023:0] m_hold = '0;
  bit            m_id = 0;
  bit            m_last = 1;
  logic [31:0]   m_cnt0 = '0;
  logic [31:0]   m_cnt1 = '0;
  int            acc_cyc_q[$];
  bit            acc_id_q[$];
  logic [1023:0] res_q[$];
  int            rise_q[$];

  // scoreboard: compare DUT against the model on every falling edge
  initial begin
    bit   exp_valid, e_r0, e_r1, prev_valid, gid;
    state_t e_state;
    logic [1:0] gop;
    logic [511:0] ga, gb;
    prev_valid = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      exp_valid = m_busy && (cyc >= m_valid_cyc);
      if (rst || m_busy) begin
        e_r0 = 0; e_r1 = 0;
      end else if (req0_valid && req1_valid) begin
        e_r0 = m_last; e_r1 = !m_last;
      end else begin
        e_r0 = req0_valid; e_r1 = req1_valid;
      end
      e_state = !m_busy ? ST_IDLE : (exp_valid ? ST_DONE : ST_BUSY);
      chk("req0_ready", 1024'(req0_ready), 1024'(e_r0));
      chk("req1_ready", 1024'(req1_ready), 1024'(e_r1));
      chk("out_valid", 1024'(out_valid), 1024'(exp_valid));
      chk("out_result", out_result, exp_valid ? m_res : m_hold);
      chk("state", 1024'(dbg_state), 1024'(e_state));
      if (exp_valid) chk("out_id", 1024'(out_id), 1024'(m_id));
`ifdef ALU_ARB_STATS_EN
      chk("grant_cnt0", 1024'(grant_cnt0), 1024'(m_cnt0));
      chk("grant_cnt1", 1024'(grant_cnt1), 1024'(m_cnt1));
`endif
      if (out_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = out_valid;
      // advance the model across the coming rising edge
      if (rst) begin
        m_busy = 0; m_last = 1; m_hold = '0; m_cnt0 = '0; m_cnt1 = '0;
      end else if (e_r0 || e_r1) begin
        gid = e_r1;
        gop = gid ? req1_operation : req0_operation;
        ga  = gid ? req1_operand1  : req0_operand1;
        gb  = gid ? req1_operand2  : req0_operand2;
        m_res = ref_alu(gop, ga, gb);
        m_valid_cyc = cyc + 1 + ref_lat(gop);
        m_busy = 1; m_id = gid; m_last = gid;
        if (gid) m_cnt1 = m_cnt1 + 1; else m_cnt0 = m_cnt0 + 1;
        acc_cyc_q.push_back(cyc);
        acc_id_q.push_back(gid);
      end else if (exp_valid && out_ready) begin
        m_busy = 0; m_hold = m_res;
        res_q.push_back(m_res);
      end
    end
  end

  // driver tasks
  task automatic send(input bit id, input logic [1:0] op, input logic [511:0] a, input logic [511:0] b);
    if (id == 0) begin
      req0_valid = 1; req0_operation = op; req0_operand1 = a; req0_operand2 = b;
    end else begin
      req1_valid = 1; req1_operation = op; req1_operand1 = a; req1_operand2 = b;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        return;
      end
    end
    fail_timeout("send");
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        @(posedge clk); #1;
        return;
      end
    end
    fail_timeout("wait_done");
  endtask

  function automatic logic [511:0] pick512();
    logic [511:0] r;
    case ($urandom_range(0, 3))
      0: r = '1;
      1: r = 512'($urandom_range(0, 20));
      default: for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    endcase
    return r;
  endfunction

  // stimulus
  initial begin
    logic [511:0]  ones, one;
    logic [1023:0] two512, sq;
    int base, rsz, xsz;
    ones = '1; one = 512'd1;
    two512 = '0; two512[512] = 1'b1;
    sq = '0; sq[0] = 1'b1;
    for (int i = 513; i < 1024; i++) sq[i] = 1'b1;

    rst = 1; out_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_operation = 0; req1_operation = 0;
    req0_operand1 = '0; req0_operand2 = '0; req1_operand1 = '0; req1_operand2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 1024'(out_valid), 1024'(0));
    chk("reset_out_result", out_result, '0);
    chk("reset_out_id", 1024'(out_id), 1024'(0));
    @(posedge clk); #1 rst = 0;

    // pin the model with hand-derived values
    chk("model_add_carry", ref_alu(OP_ADD, ones, one), two512);
    chk("model_mul_small", ref_alu(OP_MUL, 512'd3, 512'd5), 1024'd15);
    chk("model_mul_max", ref_alu(OP_MUL, ones, ones), sq);
    chk("model_invalid", ref_alu(2'b11, ones, ones), '0);

    // req0 addition with carry out
    send(0, OP_ADD, ones, one);
    wait_done();
    chk("add_result", res_q[res_q.size()-1], two512);
    chk("add_id", 1024'(acc_id_q[acc_id_q.size()-1]), 1024'(0));
    chk("add_latency", 1024'(rise_q[rise_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-1] - 1), 1024'(1));

    // req1 multiplication
    send(1, OP_MUL, 512'd3, 512'd5);
    wait_done();
    chk("mul_result", res_q[res_q.size()-1], 1024'd15);
    chk("mul_id", 1024'(acc_id_q[acc_id_q.size()-1]), 1024'(1));
    chk("mul_latency", 1024'(rise_q[rise_q.size()-1] - acc_cyc_q[acc_cyc_q.size()-1] - 1), 1024'(4));

    // invalid op with consumer stalled
    out_ready = 0;
    send(0, 2'b11, pick512(), pick512());
    repeat (6) @(negedge clk);
    chk("stall_out_valid", 1024'(out_valid), 1024'(1));
    chk("stall_out_result", out_result, '0);
    chk("stall_out_id", 1024'(out_id), 1024'(0));
    @(posedge clk); #1 out_ready = 1;
    wait_done();

    // reset two cycles into a multiply
    send(0, OP_MUL, 512'd7, 512'd9);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    rsz = rise_q.size(); xsz = res_q.size();
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_valid", 1024'(rise_q.size()), 1024'(rsz));
    chk("abort_no_result", 1024'(res_q.size()), 1024'(xsz));

    // both requesters continuously valid: alternate grants
    base = acc_id_q.size();
    req0_operation = OP_ADD; req1_operation = OP_ADD;
    req0_operand1 = pick512(); req0_operand2 = pick512();
    req1_operand1 = pick512(); req1_operand2 = pick512();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 100 && acc_id_q.size() < base + 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    wait_done();
    if (acc_id_q.size() >= base + 4) begin
      chk("rr_grant0", 1024'(acc_id_q[base]),   1024'(0));
      chk("rr_grant1", 1024'(acc_id_q[base+1]), 1024'(1));
      chk("rr_grant2", 1024'(acc_id_q[base+2]), 1024'(0));
      chk("rr_grant3", 1024'(acc_id_q[base+3]), 1024'(1));
      for (int k = 1; k < 4; k++)
        chk("rr_gap", 1024'(acc_cyc_q[base+k] - acc_cyc_q[base+k-1]), 1024'(3));
    end else begin
      fail_timeout("rr_grants");
    end

`ifdef ALU_ARB_STATS_EN
    rst = 1; @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 3; k++) begin send(0, OP_ADD, pick512(), pick512()); wait_done(); end
    for (int k = 0; k < 2; k++) begin send(1, OP_MUL, pick512(), pick512()); wait_done(); end
    chk("stats_cnt0", 1024'(grant_cnt0), 1024'(3));
    chk("stats_cnt1", 1024'(grant_cnt1), 1024'(2));
    @(negedge clk); #1;
    dut.r_grant_cnt0 = 32'hFFFF_FFFF;
    m_cnt0 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    send(0, OP_ADD, pick512(), pick512());
    wait_done();
    chk("stats_wrap", 1024'(grant_cnt0), 1024'(0));
`endif

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 6);
      req0_operation = 2'($urandom_range(0, 3));
      req1_operation = 2'($urandom_range(0, 3));
      req0_operand1 = pick512(); req0_operand2 = pick512();
      req1_operand1 = pick512(); req1_operand2 = pick512();
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: ADD_LAT, default 1, cycles from acceptance to result for operation 2'b00; legal range 1..15.
REQ-002 Parameter: MUL_LAT, default 4, cycles from acceptance to result for operation 2'b01; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req0_valid / req1_valid  input  1  requester N presents a command.
REQ-006 Port: req0_ready / req1_ready  output  1  command from requester N accepted this cycle when valid is also high.
REQ-007 Port: req0_operand1, req0_operand2, req1_operand1, req1_operand2  input  512 each  unsigned operands.
REQ-008 Port: req0_operation / req1_operation  input  2  00 addition, 01 multiplication, 10/11 invalid.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: out_result  output  1024  zero-extended sum or full product.
REQ-012 Port: out_id  output  1  index of requester owning out_result.

Function
REQ-013 FSM states IDLE, BUSY, DONE; at most one command in flight; no acceptance outside IDLE.
REQ-014 IDLE: reqN_ready asserted combinationally only for the arbitration winner; the other ready low; both low when neither valid.
REQ-015 Arbitration: single valid requester wins; both valid -> requester not in last_grant wins (round-robin); last_grant updates only on acceptance.
REQ-016 Acceptance: operands, operation and id registered; ALU inputs driven only from these registers; IDLE -> BUSY with countdown loaded to latency-1.
REQ-017 Latency: ADD_LAT for 00, MUL_LAT for 01, 1 for 10/11; out_valid rises exactly latency cycles after the accept edge.
REQ-018 BUSY: countdown decrements each cycle; at zero, ALU result captured into out_result, BUSY -> DONE.
REQ-019 Invalid operation: out_result = 0, out_valid still asserted with correct out_id.
REQ-020 Addition: 513-bit carry preserved in bit 512, bits 1023:513 zero; multiplication: full 1024-bit product, no truncation.
REQ-021 DONE: out_valid, out_result, out_id held stable until out_valid && out_ready; then -> IDLE, out_valid low next cycle.
REQ-022 Back-to-back: a new command is accepted no earlier than the cycle after the result handshake (IDLE cycle).
REQ-023 out_result retains last value after handshake; only out_valid qualifies it.

Reset
REQ-024 rst high: state IDLE, out_valid 0, out_result 0, out_id 0, countdown 0, last_grant 1 (requester 0 wins first tie), both readies 0 during reset.
REQ-025 Reset mid-BUSY or mid-DONE discards the in-flight command; no result emitted afterwards.

Configuration
REQ-026 Macro ALU_ARB_STATS_EN defined: outputs grant_cnt0, grant_cnt1 (32 bits each) count accepted commands per requester, reset to 0, wrap from 2^32-1 to 0.
REQ-027 Macro ALU_ARB_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-028 Shared package alu_pkg holds: operation codes OP_ADD=2'b00, OP_MUL=2'b01; OPERAND_W=512, RESULT_W=1024; FSM state typedef.
REQ-029 Exactly one sub-module: the existing ALU instance, operand1/operand2/operation from the command registers, result sampled at countdown zero.

Verification
REQ-030 Req0 only, op 00, 0xFFFF...F (512 ones) + 1 -> out_result = 2^512, out_id 0, out_valid 1 cycle after accept (ADD_LAT=1).
REQ-031 Req1 only, op 01, 3 * 5 -> out_result 15, out_id 1, out_valid exactly 4 cycles after accept.
REQ-032 Both valid continuously after reset, out_ready=1 -> grant order 0,1,0,1; each accept separated by result handshake plus one IDLE cycle.
REQ-033 Op 2'b11 from req0 -> out_result 0 one cycle after accept; out_ready held low 5 cycles -> out_valid/result/id stable throughout.
REQ-034 rst asserted 2 cycles into a multiply -> out_valid 0, no result afterwards; next tie grants requester 0.
REQ-035 With ALU_ARB_STATS_EN: 3 accepts from req0, 2 from req1 -> grant_cnt0 3, grant_cnt1 2; counter preset near 2^32-1 wraps to 0.
